// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM command arbiter.
// Pure declarations: no latency, no flow control.
package psram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   typedef enum logic {
      OWN_V = 1'b0,
      OWN_C = 1'b1
   } owner_t;

   localparam logic [7:0] MASK_ALL  = 8'hFF;
   localparam logic [7:0] MASK_NONE = 8'h00;

   localparam int TCMD_WR_DEF     = 14;
   localparam int BURST_BEATS_DEF = 4;

endpackage

// File: rtl/psram_arb_prio.sv
// Winner select between V and C with a saturating CPU starvation counter.
// Pick is combinational while enabled; grant pulses are registered one cycle later.
module psram_arb_prio #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_en,
   input  logic i_v_req,
   input  logic i_c_req,
   output logic o_pick_v,
   output logic o_pick_c,
   output logic o_gnt_v,
   output logic o_gnt_c
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
   localparam logic [SW-1:0] S_ONE = SW'(1);

   logic [SW-1:0] r_starve;
   logic          r_gnt_v;
   logic          r_gnt_c;
   logic          w_pick_v;
   logic          w_pick_c;

   // C only overtakes a pending V once V has won STARVE_MAX times in a row
   assign w_pick_c = i_en && i_c_req && (!i_v_req || (r_starve == S_MAX));
   assign w_pick_v = i_en && i_v_req && !w_pick_c;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_starve <= '0;
         r_gnt_v  <= 1'b0;
         r_gnt_c  <= 1'b0;
      end else begin
         r_gnt_v <= w_pick_v;
         r_gnt_c <= w_pick_c;
         if (w_pick_c || !i_c_req) begin
            r_starve <= '0;
         end else if (w_pick_v && (r_starve != S_MAX)) begin
            r_starve <= r_starve + S_ONE;
         end
      end
   end

   assign o_pick_v = w_pick_v;
   assign o_pick_c = w_pick_c;
   assign o_gnt_v  = r_gnt_v;
   assign o_gnt_c  = r_gnt_c;

endmodule

// File: rtl/psram_cmd_arbiter.sv
// Two-client PSRAM command arbiter: V has priority, C starvation bounded; issue 1 cycle after req, requests wait while busy.
// Defining PSRAM_ARB_TIMEOUT_EN adds a read watchdog that ends a stalled burst and sets sticky err.
module psram_cmd_arbiter
   import psram_arb_pkg::*;
#(
   parameter int ADDR_W         = 21,
   parameter int DATA_W         = 64,
   parameter int BURST_BEATS    = BURST_BEATS_DEF,
   parameter int TCMD_WR        = TCMD_WR_DEF,
   parameter int CPU_STARVE_MAX = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              init_calib,
   input  logic              v_req,
   input  logic [ADDR_W-1:0] v_addr,
   output logic              v_gnt,
   output logic              v_rvalid,
   output logic [DATA_W-1:0] v_rdata,
   output logic              v_done,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   input  logic [7:0]        c_mask,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_done,
   output logic              cmd_en,
   output logic              cmd,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [7:0]        data_mask,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_data_valid,
   output logic              busy,
   output logic              err
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > TCMD_WR) ? TIMEOUT_CYCLES : TCMD_WR;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(TCMD_WR - 1);
   localparam logic [1:0]       BEAT_LAST = 2'(BURST_BEATS - 1);

   state_t            r_state;
   owner_t            r_owner;
   logic              r_cmd;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [7:0]        r_mask;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_beat;

   logic w_pick_v, w_pick_c, w_gnt_v, w_gnt_c;
   logic w_beat, w_last, w_tmo, w_rd_end, w_wr_end;

   psram_arb_prio #(
      .STARVE_MAX (CPU_STARVE_MAX)
   ) u_prio (
      .clk      (clk),
      .resetn   (resetn),
      .i_en     ((r_state == IDLE) && init_calib),
      .i_v_req  (v_req),
      .i_c_req  (c_req),
      .o_pick_v (w_pick_v),
      .o_pick_c (w_pick_c),
      .o_gnt_v  (w_gnt_v),
      .o_gnt_c  (w_gnt_c)
   );

   assign w_beat   = (r_state == RD_WAIT) && rd_data_valid;
   assign w_last   = w_beat && (r_beat == BEAT_LAST);
   assign w_wr_end = (r_state == WR_WAIT) && (r_cnt == WR_LAST);

`ifdef PSRAM_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES);
   logic r_err;

   assign w_tmo = (r_state == RD_WAIT) && (r_cnt == TMO_LAST) && !w_last;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_err <= 1'b0;
      end else if (w_tmo) begin
         r_err <= 1'b1;
      end
   end
   assign err = r_err;
`else
   assign w_tmo = 1'b0;
   assign err   = 1'b0;
`endif

   assign w_rd_end = w_last || w_tmo;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_owner <= OWN_V;
         r_cmd   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_mask  <= MASK_ALL;
         r_cnt   <= '0;
         r_beat  <= '0;
      end else begin
         // Controller only sees a real mask on the issue cycle
         r_mask <= MASK_ALL;
         case (r_state)
            IDLE: begin
               r_cnt  <= '0;
               r_beat <= '0;
               if (w_pick_c) begin
                  r_owner <= OWN_C;
                  r_cmd   <= c_we;
                  r_addr  <= c_addr;
                  r_mask  <= c_we ? c_mask : MASK_NONE;
                  if (c_we) begin
                     r_wdata <= c_wdata;
                     r_state <= WR_WAIT;
                  end else begin
                     r_state <= RD_WAIT;
                  end
               end else if (w_pick_v) begin
                  r_owner <= OWN_V;
                  r_cmd   <= 1'b0;
                  r_addr  <= v_addr;
                  r_mask  <= MASK_NONE;
                  r_state <= RD_WAIT;
               end
            end
            WR_WAIT: begin
               r_cnt <= r_cnt + CNT_ONE;
               if (w_wr_end) r_state <= IDLE;
            end
            RD_WAIT: begin
               r_cnt <= r_cnt + CNT_ONE;
               if (w_beat) r_beat <= r_beat + 2'd1;
               if (w_rd_end) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign v_gnt     = w_gnt_v;
   assign c_gnt     = w_gnt_c;
   assign cmd_en    = w_gnt_v | w_gnt_c;
   assign cmd       = r_cmd;
   assign addr      = r_addr;
   assign wr_data   = r_wdata;
   assign data_mask = r_mask;
   assign busy      = (r_state != IDLE);

   assign v_rvalid = w_beat && (r_owner == OWN_V);
   assign c_rvalid = w_beat && (r_owner == OWN_C);
   assign v_rdata  = v_rvalid ? rd_data : '0;
   assign c_rdata  = c_rvalid ? rd_data : '0;
   assign v_done   = w_rd_end && (r_owner == OWN_V);
   assign c_done   = (w_rd_end && (r_owner == OWN_C)) || w_wr_end;

endmodule
